// File: rtl/audio_stream_pkg.sv
// Shared types, frame geometry and slot helpers for the I2S codec stream endpoint.
package audio_stream_pkg;

    typedef logic [15:0] sample_t;

    localparam int unsigned SAMPLE_BITS     = 16;
    localparam int unsigned SLOT_BITS       = 32;
    localparam int unsigned FRAME_BITS      = 64;
    localparam int unsigned DATA_FIRST_SLOT = 1;
    localparam int unsigned DATA_LAST_SLOT  = 16;

    localparam int unsigned SLOT_W    = $clog2(SLOT_BITS);
    localparam int unsigned FRAME_W   = $clog2(FRAME_BITS);
    localparam int unsigned BIT_IDX_W = $clog2(SAMPLE_BITS);

    typedef logic [SLOT_W-1:0]  slot_t;
    typedef logic [FRAME_W-1:0] frame_cnt_t;

    function automatic logic is_data_slot(input slot_t s);
        return (32'(s) >= DATA_FIRST_SLOT) && (32'(s) <= DATA_LAST_SLOT);
    endfunction

    // I2S one-BCLK delay: slot 1 carries bit 15, slot 16 carries bit 0.
    function automatic logic [BIT_IDX_W-1:0] data_bit_idx(input slot_t s);
        return BIT_IDX_W'(DATA_LAST_SLOT - 32'(s));
    endfunction

endpackage

// File: rtl/audio_codec_stream_clkgen.sv
// BCLK/LRCK generator: clk divider, 64-slot frame counter and one-cycle BCLK edge strobes.
module i2s_clkgen
    import audio_stream_pkg::*;
#(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic       bclk_o,
    output logic       lrck_o,
    output frame_cnt_t bit_cnt_o,
    output logic       rise_o,
    output logic       fall_o
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    frame_cnt_t       bit_cnt_q, bit_cnt_d;
    logic             tc;

    assign tc = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = tc ? '0 : div_cnt_q + 1'b1;
        bclk_d    = bclk_q ^ tc;
        bit_cnt_d = (tc && bclk_q) ? bit_cnt_q + 1'b1 : bit_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= '1;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Strobes are high in the cycle before bclk changes, so anything they
    // enable updates on the same clk edge as the bclk pin.
    assign rise_o    = tc && !bclk_q;
    assign fall_o    = tc && bclk_q;
    assign bclk_o    = bclk_q;
    assign bit_cnt_o = bit_cnt_q;
    assign lrck_o    = bit_cnt_q[FRAME_W-1];

endmodule

// File: rtl/audio_codec_stream.sv
// I2S master-clock endpoint for the audio codec: ADC deserializer sources, DAC serializer sinks.
// Optional sticky overrun/underrun status ports are enabled with AUDIO_STREAM_STATUS_EN.
module audio_codec_stream
    import audio_stream_pkg::*;
#(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic    clk,
    input  logic    reset,
    output sample_t adc_left_data,
    output sample_t adc_right_data,
    output logic    adc_left_valid,
    output logic    adc_right_valid,
    input  logic    adc_left_ready,
    input  logic    adc_right_ready,
    input  sample_t dac_left_data,
    input  sample_t dac_right_data,
    input  logic    dac_left_valid,
    input  logic    dac_right_valid,
    output logic    dac_left_ready,
    output logic    dac_right_ready,
    output logic    bclk,
    output logic    lrck,
    output logic    dacdat,
    input  logic    adcdat
`ifdef AUDIO_STREAM_STATUS_EN
    ,
    input  logic       status_clear,
    output logic [1:0] adc_overrun,
    output logic [1:0] dac_underrun
`endif
);

    frame_cnt_t bit_cnt, bit_nxt;
    slot_t      slot, slot_nxt;
    logic       bclk_rise, bclk_fall;

    i2s_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk_i     (clk),
        .rst_ni    (reset),
        .bclk_o    (bclk),
        .lrck_o    (lrck),
        .bit_cnt_o (bit_cnt),
        .rise_o    (bclk_rise),
        .fall_o    (bclk_fall)
    );

    assign bit_nxt  = bit_cnt + 1'b1;
    assign slot     = bit_cnt[SLOT_W-1:0];
    assign slot_nxt = bit_nxt[SLOT_W-1:0];

    // Index 0 = left, 1 = right throughout.
    sample_t [1:0] dac_data_w, shift_w, adc_data_w;
    logic    [1:0] dac_valid_w, dac_ready_w, adc_valid_w, adc_ready_w;

`ifdef AUDIO_STREAM_STATUS_EN
    logic [1:0] ovr_set, und_set;
`endif

    assign dac_data_w  = {dac_right_data, dac_left_data};
    assign dac_valid_w = {dac_right_valid, dac_left_valid};
    assign adc_ready_w = {adc_right_ready, adc_left_ready};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        localparam logic CH = 1'(c);

        sample_t hold_q, hold_d, shift_q, shift_d;
        sample_t sr_q, sr_d, data_q, data_d;
        logic    full_q, full_d, valid_q, valid_d;
        logic    accept, load, shift_en, word_done;

        assign accept    = dac_valid_w[c] && !full_q;
        assign load      = bclk_fall && (bit_nxt == {CH, SLOT_W'(0)});
        assign shift_en  = bclk_rise && (bit_cnt[FRAME_W-1] == CH) && is_data_slot(slot);
        assign word_done = shift_en && (32'(slot) == DATA_LAST_SLOT);

        always_comb begin
            hold_d  = hold_q;
            full_d  = full_q;
            shift_d = shift_q;
            sr_d    = sr_q;
            data_d  = data_q;
            valid_d = valid_q;

            if (accept) begin
                hold_d = dac_data_w[c];
                full_d = 1'b1;
            end else if (load) begin
                full_d = 1'b0;
            end
            // An empty holding register leaves the shift register untouched,
            // so the previous sample is replayed.
            if (load && full_q) begin
                shift_d = hold_q;
            end

            if (shift_en) begin
                sr_d = {sr_q[SAMPLE_BITS-2:0], adcdat};
            end
            if (word_done) begin
                data_d  = sr_d;
                valid_d = 1'b1;
            end else if (valid_q && adc_ready_w[c]) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                hold_q  <= '0;
                full_q  <= 1'b0;
                shift_q <= '0;
                sr_q    <= '0;
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                hold_q  <= hold_d;
                full_q  <= full_d;
                shift_q <= shift_d;
                sr_q    <= sr_d;
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign dac_ready_w[c] = !full_q;
        assign shift_w[c]     = shift_q;
        assign adc_data_w[c]  = data_q;
        assign adc_valid_w[c] = valid_q;

`ifdef AUDIO_STREAM_STATUS_EN
        assign ovr_set[c] = word_done && valid_q && !adc_ready_w[c];
        assign und_set[c] = load && !full_q;
`endif
    end

    logic dacdat_q, dacdat_d;

    always_comb begin
        dacdat_d = dacdat_q;
        if (bclk_fall) begin
            dacdat_d = 1'b0;
            if (is_data_slot(slot_nxt)) begin
                dacdat_d = shift_w[bit_nxt[FRAME_W-1]][data_bit_idx(slot_nxt)];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dacdat_q <= 1'b0;
        end else begin
            dacdat_q <= dacdat_d;
        end
    end

`ifdef AUDIO_STREAM_STATUS_EN
    logic [1:0] ovr_q, ovr_d, und_q, und_d;

    always_comb begin
        ovr_d = (ovr_q & ~{2{status_clear}}) | ovr_set;
        und_d = (und_q & ~{2{status_clear}}) | und_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr_q <= '0;
            und_q <= '0;
        end else begin
            ovr_q <= ovr_d;
            und_q <= und_d;
        end
    end

    assign adc_overrun  = ovr_q;
    assign dac_underrun = und_q;
`endif

    assign dacdat          = dacdat_q;
    assign adc_left_data   = adc_data_w[0];
    assign adc_right_data  = adc_data_w[1];
    assign adc_left_valid  = adc_valid_w[0];
    assign adc_right_valid = adc_valid_w[1];
    assign dac_left_ready  = dac_ready_w[0];
    assign dac_right_ready = dac_ready_w[1];

endmodule

// File: tb/tb_audio_codec_stream.sv
// Directed self-checking bench for audio_codec_stream with a simple I2S codec model (CLK_DIV = 2).
module tb_audio_codec_stream;

    logic        clk;
    logic        reset;
    logic [15:0] adc_left_data, adc_right_data;
    logic        adc_left_valid, adc_right_valid;
    logic        adc_left_ready, adc_right_ready;
    logic [15:0] dac_left_data, dac_right_data;
    logic        dac_left_valid, dac_right_valid;
    logic        dac_left_ready, dac_right_ready;
    logic        bclk, lrck, dacdat, adcdat;
`ifdef AUDIO_STREAM_STATUS_EN
    logic        status_clear;
    logic [1:0]  adc_overrun, dac_underrun;
`endif

    audio_codec_stream #(
        .CLK_DIV(2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .adc_left_data   (adc_left_data),
        .adc_right_data  (adc_right_data),
        .adc_left_valid  (adc_left_valid),
        .adc_right_valid (adc_right_valid),
        .adc_left_ready  (adc_left_ready),
        .adc_right_ready (adc_right_ready),
        .dac_left_data   (dac_left_data),
        .dac_right_data  (dac_right_data),
        .dac_left_valid  (dac_left_valid),
        .dac_right_valid (dac_right_valid),
        .dac_left_ready  (dac_left_ready),
        .dac_right_ready (dac_right_ready),
        .bclk            (bclk),
        .lrck            (lrck),
        .dacdat          (dacdat),
        .adcdat          (adcdat)
`ifdef AUDIO_STREAM_STATUS_EN
        ,
        .status_clear    (status_clear),
        .adc_overrun     (adc_overrun),
        .dac_underrun    (dac_underrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Codec model: tracks the frame from bclk, drives adcdat after each fall,
    // captures dacdat at each rise.
    logic [5:0]  tb_bit;
    logic        prevb;
    logic        cap [64];
    logic [15:0] adc_l, adc_r, word_m;
    int          slot_m;

    always @(negedge clk) begin
        if (!reset) begin
            tb_bit = 6'd63;
            prevb  = 1'b0;
            adcdat = 1'b0;
        end else begin
            if (prevb && !bclk) begin
                tb_bit = tb_bit + 6'd1;
                slot_m = int'(tb_bit[4:0]);
                word_m = tb_bit[5] ? adc_r : adc_l;
                if (slot_m >= 1 && slot_m <= 16) adcdat = word_m[16-slot_m];
                else adcdat = 1'b0;
            end else if (!prevb && bclk) begin
                cap[tb_bit] = dacdat;
            end
            prevb = bclk;
        end
    end

    logic last_bclk;
    logic seen_lvalid;

    task automatic tick();
        last_bclk = bclk;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stops just after the requested bclk edge; for a fall, bitn is the slot being left.
    task automatic wait_edge(input logic rise, input logic [5:0] bitn);
        int unsigned n;
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 2000) begin
            tick();
            n++;
            if (bclk === rise && last_bclk === !rise && tb_bit === bitn) hit = 1'b1;
            else if (adc_left_valid === 1'b1) seen_lvalid = 1'b1;
        end
        total++;
        assert (hit) else begin
            bad++;
            $error("FAIL wait_edge bit=%0d observed=timeout expected=edge", bitn);
        end
    endtask

    task automatic decode(output logic [15:0] l, output logic [15:0] r, output logic [63:0] other);
        l     = '0;
        r     = '0;
        other = '0;
        for (int i = 0; i < 64; i++) begin
            if (i >= 1 && i <= 16) l[16-i] = cap[i];
            else if (i >= 33 && i <= 48) r[48-i] = cap[i];
            else other[i] = cap[i];
        end
    endtask

    logic [15:0] dec_l, dec_r;
    logic [63:0] dec_o;

    initial begin
        reset           = 1'b0;
        adc_left_ready  = 1'b1;
        adc_right_ready = 1'b1;
        dac_left_data   = '0;
        dac_right_data  = '0;
        dac_left_valid  = 1'b0;
        dac_right_valid = 1'b0;
        adc_l           = 16'hA5C3;
        adc_r           = 16'h1234;
        last_bclk       = 1'b0;
        seen_lvalid     = 1'b0;
`ifdef AUDIO_STREAM_STATUS_EN
        status_clear    = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_bclk", bclk, 0);
        chk("rst_lrck", lrck, 1);
        chk("rst_dacdat", dacdat, 0);
        chk("rst_lvalid", adc_left_valid, 0);
        chk("rst_rvalid", adc_right_valid, 0);
        chk("rst_ldata", adc_left_data, 0);
        chk("rst_rdata", adc_right_data, 0);
        chk("rst_lready", dac_left_ready, 1);
        chk("rst_rready", dac_right_ready, 1);

        reset = 1'b1;
        tick(); chk("clk0_bclk", bclk, 0); chk("clk0_lrck", lrck, 1);
        tick(); chk("clk1_bclk", bclk, 1); chk("clk1_lrck", lrck, 1);
        tick(); chk("clk2_bclk", bclk, 1);
        tick(); chk("clk3_bclk", bclk, 0); chk("first_fall_lrck", lrck, 0);
        repeat (127) tick();
        chk("lrck_hold_left", lrck, 0);
        tick();
        chk("lrck_to_right", lrck, 1);

        wait_edge(1'b1, 6'd16);
        chk("adc_l_valid", adc_left_valid, 1);
        chk("adc_l_data", adc_left_data, 16'hA5C3);
        tick();
        chk("adc_l_valid_1clk", adc_left_valid, 0);
        adc_l          = 16'h0001;
        adc_left_ready = 1'b0;
        wait_edge(1'b1, 6'd48);
        chk("adc_r_valid", adc_right_valid, 1);
        chk("adc_r_data", adc_right_data, 16'h1234);
        tick();
        chk("adc_r_valid_1clk", adc_right_valid, 0);

        wait_edge(1'b1, 6'd16);
        chk("ovr_first_valid", adc_left_valid, 1);
        chk("ovr_first_data", adc_left_data, 16'h0001);
        adc_l = 16'h0002;
        wait_edge(1'b1, 6'd16);
        repeat (4) tick();
        chk("ovr_valid_held", adc_left_valid, 1);
        chk("ovr_data_new", adc_left_data, 16'h0002);
`ifdef AUDIO_STREAM_STATUS_EN
        chk("ovr_flag", adc_overrun, 2'b01);
`endif
        adc_left_ready = 1'b1;
        tick();
        chk("ovr_accept", adc_left_valid, 0);
        adc_l = 16'h5A3C;

        dac_left_data   = 16'h8001;
        dac_right_data  = 16'h7FFE;
        dac_left_valid  = 1'b1;
        dac_right_valid = 1'b1;
        tick();
        dac_left_valid  = 1'b0;
        dac_right_valid = 1'b0;
        chk("dac_l_ready_drop", dac_left_ready, 0);
        chk("dac_r_ready_drop", dac_right_ready, 0);
        wait_edge(1'b0, 6'd31);
        chk("dac_r_ready_back", dac_right_ready, 1);
        chk("dac_l_ready_still", dac_left_ready, 0);
        wait_edge(1'b0, 6'd63);
        chk("dac_l_ready_back", dac_left_ready, 1);
        wait_edge(1'b0, 6'd0);
        chk("dac_msb_at_fall", dacdat, 1);
        wait_edge(1'b0, 6'd63);
        decode(dec_l, dec_r, dec_o);
        chk("dac_frame_l", dec_l, 16'h8001);
        chk("dac_frame_r", dec_r, 16'h7FFE);
        chk("dac_frame_zero", dec_o[31:0], 0);
        chk("dac_frame_zero_hi", dec_o[63:32], 0);

        wait_edge(1'b0, 6'd63);
        decode(dec_l, dec_r, dec_o);
        chk("underrun_l", dec_l, 16'h8001);
        chk("underrun_r", dec_r, 16'h7FFE);
`ifdef AUDIO_STREAM_STATUS_EN
        chk("underrun_flag", dac_underrun[0], 1);
        status_clear = 1'b1;
        tick();
        status_clear = 1'b0;
        chk("underrun_clear", dac_underrun[0], 0);
`endif

        dac_left_data  = 16'h0100;
        dac_left_valid = 1'b1;
        tick();
        dac_left_valid = 1'b0;
        wait_edge(1'b0, 6'd63);
        wait_edge(1'b0, 6'd7);
        chk("pre_rst_dacdat", dacdat, 1);
        chk("pre_rst_ldata", adc_left_data, 16'h5A3C);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_bclk", bclk, 0);
        chk("mid_rst_lrck", lrck, 1);
        chk("mid_rst_dacdat", dacdat, 0);
        chk("mid_rst_ldata", adc_left_data, 0);
        chk("mid_rst_lvalid", adc_left_valid, 0);
        chk("mid_rst_lready", dac_left_ready, 1);
        repeat (3) tick();
        reset       = 1'b1;
        seen_lvalid = 1'b0;
        wait_edge(1'b1, 6'd16);
        chk("no_partial_word", seen_lvalid, 0);
        chk("post_rst_lvalid", adc_left_valid, 1);
        chk("post_rst_ldata", adc_left_data, 16'h5A3C);
        wait_edge(1'b0, 6'd63);
        decode(dec_l, dec_r, dec_o);
        chk("post_rst_dac_l", dec_l, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
